// File: rtl/next_pc_gen_if.sv
// Purpose: bundles the redirect/stall request side and the fetch-PC result side of
//          next_pc_gen into one interface.
// Signals:
//   stall, redir_valid, redir_mode, redir_base, redir_imm, redir_rs1, fault_clear  -> generator
//   pc_slot, fetch_valid, redirect_taken, misalign_fault, fault_pc                 <- generator
// Modports: master = pipeline side (drives requests), slave = the PC generator.
interface next_pc_gen_if #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned FETCH_WIDTH = 2
);
    logic                          stall;
    logic                          redir_valid;
    logic [1:0]                    redir_mode;
    logic [XLEN-1:0]               redir_base;
    logic [XLEN-1:0]               redir_imm;
    logic [XLEN-1:0]               redir_rs1;
    logic                          fault_clear;
    logic [FETCH_WIDTH*XLEN-1:0]   pc_slot;
    logic                          fetch_valid;
    logic                          redirect_taken;
    logic                          misalign_fault;
    logic [XLEN-1:0]               fault_pc;

    modport master (
        output stall, redir_valid, redir_mode, redir_base, redir_imm, redir_rs1, fault_clear,
        input  pc_slot, fetch_valid, redirect_taken, misalign_fault, fault_pc
    );

    modport slave (
        input  stall, redir_valid, redir_mode, redir_base, redir_imm, redir_rs1, fault_clear,
        output pc_slot, fetch_valid, redirect_taken, misalign_fault, fault_pc
    );
endinterface

// File: rtl/next_pc_gen.sv
// Purpose: fetch-PC generator. Issues FETCH_WIDTH consecutive word PCs per cycle,
//          applies execute-stage redirects (branch/jal/jalr/trap), holds across stalls
//          while remembering a redirect that arrived mid-stall, and parks in a fault
//          state on a misaligned target until fault_clear.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active-high
//   bus  - next_pc_gen_if.slave: redirect/stall inputs, pc_slot/status outputs
module next_pc_gen #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     FETCH_WIDTH = 2,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0001_0000,
    parameter logic [XLEN-1:0] TRAP_VEC    = 32'h0000_0100
) (
    input  logic         clk,
    input  logic         rst,
    next_pc_gen_if.slave bus
);
    localparam logic [XLEN-1:0] STEP = XLEN'(4 * FETCH_WIDTH);

    localparam logic [1:0] MODE_BRANCH = 2'b00;
    localparam logic [1:0] MODE_JAL    = 2'b01;
    localparam logic [1:0] MODE_JALR   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PEND  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    state_e                      state_q, state_d;
    logic [XLEN-1:0]             pc_q, pc_d;
    logic [XLEN-1:0]             pend_q, pend_d;
    logic [XLEN-1:0]             fault_pc_q, fault_pc_d;
    logic [FETCH_WIDTH*XLEN-1:0] slots_q, slots_d;
    logic                        fetch_valid_q, fetch_valid_d;
    logic                        taken_q, taken_d;
    logic                        fault_q, fault_d;

    logic [XLEN-1:0]             jalr_sum;
    logic [XLEN-1:0]             tgt;
    logic                        tgt_mis;

    // Redirect target; jalr clears bit 0 before the alignment check
    always_comb begin
        jalr_sum = bus.redir_rs1 + bus.redir_imm;
        unique case (bus.redir_mode)
            MODE_BRANCH, MODE_JAL: tgt = bus.redir_base + bus.redir_imm;
            MODE_JALR:             tgt = {jalr_sum[XLEN-1:1], 1'b0};
            default:               tgt = TRAP_VEC;
        endcase
        tgt_mis = (tgt[1:0] != 2'b00);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; IDLE treats a redirect exactly as RUN does
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (bus.redir_valid) begin
                    if (tgt_mis)        state_d = ST_FAULT;
                    else if (bus.stall) state_d = ST_PEND;
                    else                state_d = ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PEND: begin
                if (bus.redir_valid && tgt_mis) state_d = ST_FAULT;
                else if (!bus.stall)            state_d = ST_RUN;
            end
            ST_FAULT: begin
                if (bus.fault_clear) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        pc_d       = pc_q;
        pend_d     = pend_q;
        fault_pc_d = fault_pc_q;
        taken_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (bus.redir_valid) begin
                    if (tgt_mis) begin
                        fault_pc_d = tgt;
                    end else if (bus.stall) begin
                        pend_d = tgt;
                    end else begin
                        pc_d    = tgt;
                        taken_d = 1'b1;
                    end
                end else if (state_q == ST_RUN && !bus.stall) begin
                    pc_d = pc_q + STEP;
                end
            end
            ST_PEND: begin
                // A live redirect in the release cycle is newer than the stored one
                if (bus.redir_valid && tgt_mis) begin
                    fault_pc_d = tgt;
                end else if (!bus.stall) begin
                    pc_d    = bus.redir_valid ? tgt : pend_q;
                    taken_d = 1'b1;
                end else if (bus.redir_valid) begin
                    pend_d = tgt;
                end
            end
            ST_FAULT: begin
                if (bus.fault_clear) begin
                    pc_d    = TRAP_VEC;
                    taken_d = 1'b1;
                end
            end
            default: ;
        endcase

        // PEND is always left in the cycle stall drops, so valid tracks RUN
        fetch_valid_d = (state_d == ST_RUN);
        fault_d       = (state_d == ST_FAULT);

        slots_d = '0;
        for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
            slots_d[i*XLEN +: XLEN] = pc_d + XLEN'(4 * i);
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            pend_q        <= '0;
            fault_pc_q    <= '0;
            fetch_valid_q <= 1'b0;
            taken_q       <= 1'b0;
            fault_q       <= 1'b0;
            for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
                slots_q[i*XLEN +: XLEN] <= RESET_PC + XLEN'(4 * i);
            end
        end else begin
            pc_q          <= pc_d;
            pend_q        <= pend_d;
            fault_pc_q    <= fault_pc_d;
            fetch_valid_q <= fetch_valid_d;
            taken_q       <= taken_d;
            fault_q       <= fault_d;
            slots_q       <= slots_d;
        end
    end

    assign bus.pc_slot        = slots_q;
    assign bus.fetch_valid    = fetch_valid_q;
    assign bus.redirect_taken = taken_q;
    assign bus.misalign_fault = fault_q;
    assign bus.fault_pc       = fault_pc_q;
endmodule
